i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- I2S master transmitter on the system clock `clk`.
- Generates `bclk` and `lrclk` by dividing `clk`, and serialises left/right sample pairs MSB-first with the standard one-`bclk` I2S offset.
- Feeds the team's bit-serial processing chain (delay line and similar blocks), which sample `bclk`/`lrclk` edges in the `clk` domain.
- Parallel samples arrive through a one-entry valid/ready buffer.

Parameters:
- `w_sample`, 32, bits per channel word; frame is 2*`w_sample` `bclk` periods.
- `clk_div`, 4, `clk` cycles per `bclk` half-period; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  run when high; when low, idle lines and restart the frame
- `left`  in  `w_sample`  left-channel sample
- `right`  in  `w_sample`  right-channel sample
- `sample_valid`  in  1  `left`/`right` pair valid
- `sample_ready`  out  1  holding register empty
- `bclk`  out  1  bit clock, registered
- `lrclk`  out  1  word select, 0 = left, 1 = right, registered
- `sdata`  out  1  serial data, registered
- `frame_start`  out  1  one-`clk` pulse when a new pair is loaded into the shifter
- `underrun`  out  1  one-`clk` pulse when the shifter loads with the holding register empty

Behaviour:
- Reset (async) and `enable`=0 both force the same state:
  - `bclk`=0, `lrclk`=0, `sdata`=0, `frame_start`=0, `underrun`=0
  - divider count = 0, `bitcnt` = 2*`w_sample`-1, shifter = 0
- Holding register:
  - Reset clears it; `sample_ready`=1 after reset.
  - `enable`=0 does NOT clear it.
- Divider: counts 0..`clk_div`-1 while enabled. At terminal count it wraps and toggles `bclk`.
  - Strobe `fall_s` is asserted on the `clk` cycle where `bclk` goes 1→0.
  - Strobe `rise_s` is asserted where `bclk` goes 0→1.
  - The first toggle after enable is a rise.
- All data and `lrclk` updates happen only on `fall_s`, so a receiver sampling on `bclk` rise sees stable data. On each `fall_s`:
  - `bitcnt` increments, wrapping 2*`w_sample`-1 → 0.
  - `sdata` = frame bit `k`, where `k` is the new `bitcnt`.
  - Frame vector = {`left`, `right`} from the shifter, MSB first.
  - `lrclk` = 1 when `k` is in [`w_sample`-1, 2*`w_sample`-2], else 0. This makes `lrclk` change one `bclk` before each word's MSB.
- Load happens on the `fall_s` that wraps `bitcnt` to 0, with the shifter updated before bit 0 is driven:
  - Holding register full: shifter ← holding, holding empties, `frame_start` pulses.
  - Holding register empty: shifter ← 0, `frame_start` and `underrun` both pulse; output is silence.
- Handshake:
  - `sample_ready` = holding register empty, registered.
  - Transfer occurs on `clk` when `sample_valid` && `sample_ready`; `left` and `right` are captured together.
  - No bypass: a pair accepted on the same `clk` as a load with an empty holding register is NOT used for that frame. That frame underruns and the pair plays in the next frame.
  - `sample_ready` rises the `clk` after a load.
- Timing:
  - `bclk` period = 2*`clk_div` `clk` cycles.
  - Frame = 4*`w_sample`*`clk_div` `clk` cycles.
  - First `sdata` bit is driven `clk_div`*2 cycles after `enable` rises; this is the first fall.
- `enable` dropping mid-frame: all lines go to idle on the next `clk`, and the partial frame is discarded. Re-enable starts a fresh frame with a load.
- `rst` asserted mid-frame: immediate idle, holding register cleared.

Decomposition:
- Package `i2s_pkg`:
  - `localparam` for default `w_sample`
  - function `frame_bits(w)` returning 2*`w`
  - typedef `sample_pair_t` (struct of `left`, `right`)
- One natural sub-module: `i2s_clk_gen`.
  - Inputs: `clk`, `rst`, `enable`.
  - Outputs: `bclk`, `fall_s`, `rise_s`.
  - Parameter: `clk_div`.
  - Reusable by a future I2S receiver-master.

Test Plan (`w_sample`=8, `clk_div`=2):
- Reset check: assert `rst` mid-frame → outputs 0 within the same cycle (async); `sample_ready`=1 after release.
- Single pair, left=8'hA5, right=8'h3C, enable after accept:
  - `sdata` on successive `bclk` rises = 1010_0101 0011_1100.
  - `lrclk` = 0 for bits 0–6, 1 for bits 7–14, 0 for bit 15.
  - One `frame_start`, no `underrun`.
- No sample offered with enable=1 → `sdata` stays 0, `underrun` pulses every 64 `clk` cycles, `bclk` period 4 `clk`.
- Back-to-back pairs 8'h01/8'h80 then 8'hFF/8'h00 with `sample_valid` held:
  - `sample_ready` drops after accept and re-rises the `clk` after each load.
  - Both frames are contiguous, no `underrun`.
- Pair offered on the exact `clk` of a load with holding empty → `underrun` pulse for that frame, and the pair plays in the following frame.
- `enable` deasserted at bit 5 → lines idle next `clk`. Re-enable → first fall drives MSB of the held pair, `lrclk`=0.

Source files
------------

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants, types and helpers for the I2S transmit path.
//   W_SAMPLE_DEF  default bits per channel word
//   CLK_DIV_DEF   default clk cycles per bclk half-period
//   frame_bits()  bclk periods in one left/right frame
//   sample_pair_t left/right pair at the default word width
package i2s_pkg;

    localparam int W_SAMPLE_DEF = 32;
    localparam int CLK_DIV_DEF  = 4;

    function automatic int frame_bits(input int w);
        return 2 * w;
    endfunction

    // Packed so {left, right} is MSB-first frame order when flattened.
    typedef struct packed {
        logic [W_SAMPLE_DEF-1:0] left;
        logic [W_SAMPLE_DEF-1:0] right;
    } sample_pair_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: divides clk into a registered bit clock plus edge strobes.
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   enable  in   run when high; low holds bclk low and restarts the divider
//   bclk    out  registered bit clock, period 2*clk_div clk cycles
//   fall_s  out  high on the clk cycle whose edge takes bclk 1->0
//   rise_s  out  high on the clk cycle whose edge takes bclk 0->1
module i2s_clk_gen #(
    parameter int clk_div = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bclk,
    output logic fall_s,
    output logic rise_s
);

    localparam int CW = (clk_div > 1) ? $clog2(clk_div) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;
    logic          tc;

    always_comb begin
        tc     = (cnt_q == CW'(clk_div - 1));
        cnt_d  = cnt_q;
        bclk_d = bclk_q;
        if (!enable) begin
            cnt_d  = '0;
            bclk_d = 1'b0;
        end else if (tc) begin
            cnt_d  = '0;
            bclk_d = ~bclk_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Strobes are decoded from current state so the consumer updates on the
    // same edge that moves bclk.
    assign rise_s = enable && tc && !bclk_q;
    assign fall_s = enable && tc &&  bclk_q;
    assign bclk   = bclk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            bclk_q <= bclk_d;
        end
    end

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter, MSB-first with the one-bclk word offset.
//   clk, rst              system clock, asynchronous active-high reset
//   enable                run when high; low idles the lines and restarts the frame
//   left, right           parallel sample pair, captured together
//   sample_valid/ready    one-entry holding register handshake
//   bclk, lrclk, sdata    registered serial outputs (lrclk 0 = left)
//   frame_start           one-clk pulse when the shifter loads
//   underrun              one-clk pulse when the shifter loads with nothing held
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int w_sample = W_SAMPLE_DEF,
    parameter int clk_div  = CLK_DIV_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [w_sample-1:0] left,
    input  logic [w_sample-1:0] right,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                frame_start,
    output logic                underrun
);

    localparam int FB = frame_bits(w_sample);
    localparam int BW = $clog2(FB);

    logic          fall_s, rise_s;
    logic [BW-1:0] bitcnt_q, bitcnt_d;
    logic [FB-1:0] shift_q, shift_d, shift_src;
    logic [FB-1:0] hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic          frame_start_q, frame_start_d;
    logic          underrun_q, underrun_d;
    logic          accept, load;

    i2s_clk_gen #(.clk_div(clk_div)) u_clk_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bclk   (bclk),
        .fall_s (fall_s),
        .rise_s (rise_s)
    );

    always_comb begin
        accept        = sample_valid && !hold_full_q;
        load          = fall_s && (bitcnt_q == BW'(FB - 1));
        bitcnt_d      = bitcnt_q;
        shift_d       = shift_q;
        shift_src     = shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        lrclk_d       = lrclk_q;
        sdata_d       = sdata_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        // A pair accepted on a load edge is not bypassed into the shifter;
        // it stays held and plays in the following frame.
        if (accept) begin
            hold_d      = {left, right};
            hold_full_d = 1'b1;
        end
        if (load && hold_full_q) begin
            hold_full_d = 1'b0;
        end

        if (!enable) begin
            bitcnt_d = BW'(FB - 1);
            shift_d  = '0;
            lrclk_d  = 1'b0;
            sdata_d  = 1'b0;
        end else if (fall_s) begin
            bitcnt_d = load ? '0 : bitcnt_q + BW'(1);
            if (load) begin
                frame_start_d = 1'b1;
                if (hold_full_q) begin
                    shift_src = hold_q;
                end else begin
                    shift_src  = '0;
                    underrun_d = 1'b1;
                end
            end
            sdata_d = shift_src[FB-1];
            shift_d = shift_src << 1;
            // Word select leads each word's MSB by one bclk.
            lrclk_d = (bitcnt_d >= BW'(w_sample - 1)) && (bitcnt_d <= BW'(FB - 2));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitcnt_q      <= BW'(FB - 1);
            shift_q       <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            lrclk_q       <= 1'b0;
            sdata_q       <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            bitcnt_q      <= bitcnt_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            lrclk_q       <= lrclk_d;
            sdata_q       <= sdata_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign sample_ready = ~hold_full_q;
    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
module tb_i2s_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] left, right;
    logic       sample_valid;
    logic       sample_ready, bclk, lrclk, sdata, frame_start, underrun;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] cap_bits, cap_lr;
    int          cap_fs, cap_ur;

    i2s_tx #(.w_sample(8), .clk_div(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .left         (left),
        .right        (right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [7:0] l, input logic [7:0] r);
        @(negedge clk);
        left         = l;
        right        = r;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("offer_accepted", sample_ready, 0);
    endtask

    // Shift sdata/lrclk in on each bclk rise (MSB = first bit), counting pulses.
    task automatic capture(input int n, input int skip, input bit auto_drop);
        int got = 0;
        int sk  = skip;
        int cyc = 0;
        bit prev_b;
        bit pend = 0;
        cap_bits = '0;
        cap_lr   = '0;
        cap_fs   = 0;
        cap_ur   = 0;
        prev_b   = bclk;
        while (got < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (auto_drop && pend) begin
                chk("rdy_drop", sample_ready, 0);
                sample_valid = 1'b0;
            end
            pend = sample_valid && sample_ready;
            if (frame_start) begin
                cap_fs++;
                chk("rdy_after_load", sample_ready, 1);
            end
            if (underrun) cap_ur++;
            if (bclk && !prev_b) begin
                if (sk > 0) sk--;
                else begin
                    cap_bits = {cap_bits[30:0], sdata};
                    cap_lr   = {cap_lr[30:0], lrclk};
                    got++;
                end
            end
            prev_b = bclk;
        end
        if (got < n) chk("capture_timeout", got, n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        left         = '0;
        right        = '0;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_bclk", bclk, 0);
        chk("rst_sdata", sdata, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", sample_ready, 1);
        chk("post_rst_lines", {bclk, lrclk, sdata, frame_start, underrun}, 0);

        // single pair, enabled after accept
        offer(8'hA5, 8'h3C);
        enable = 1'b1;
        capture(16, 1, 0);
        chk("single_data", cap_bits[15:0], 16'hA53C);
        chk("single_lr", cap_lr[15:0], 16'h01FE);
        chk("single_fs", cap_fs, 1);
        chk("single_ur", cap_ur, 0);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);

        // idle with nothing offered: silence and periodic underrun
        begin
            int ur_n = 0, fs_n = 0, ur_first = -1, ur_last = -1;
            int rise1 = -1, rise2 = -1;
            bit sd_any = 0, prev_b = 0;
            enable = 1'b1;
            for (int i = 1; i <= 140; i++) begin
                @(negedge clk);
                if (underrun) begin
                    if (ur_first < 0) ur_first = i;
                    ur_last = i;
                    ur_n++;
                end
                if (frame_start) fs_n++;
                if (sdata) sd_any = 1;
                if (bclk && !prev_b) begin
                    if (rise1 < 0) rise1 = i;
                    else if (rise2 < 0) rise2 = i;
                end
                prev_b = bclk;
            end
            chk("ur_first_cycle", ur_first, 4);
            chk("ur_count", ur_n, 3);
            chk("ur_spacing", ur_last - ur_first, 128);
            chk("ur_fs_count", fs_n, 3);
            chk("ur_silence", sd_any, 0);
            chk("bclk_first_rise", rise1, 2);
            chk("bclk_period", rise2 - rise1, 4);
            enable = 1'b0;
            @(negedge clk);
        end

        // back-to-back pairs with valid held
        left         = 8'h01;
        right        = 8'h80;
        sample_valid = 1'b1;
        @(negedge clk);
        chk("b2b_acc1", sample_ready, 0);
        left   = 8'hFF;
        right  = 8'h00;
        enable = 1'b1;
        capture(32, 1, 1);
        sample_valid = 1'b0;
        chk("b2b_data", cap_bits, 32'h0180FF00);
        chk("b2b_lr", cap_lr, 32'h01FE01FE);
        chk("b2b_fs", cap_fs, 2);
        chk("b2b_ur", cap_ur, 0);
        chk("b2b_rdy_end", sample_ready, 1);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);

        // pair offered on the load edge with holding empty
        enable = 1'b1;
        repeat (3) @(negedge clk);
        left         = 8'hC3;
        right        = 8'h5A;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("nobyp_ur", underrun, 1);
        chk("nobyp_fs", frame_start, 1);
        chk("nobyp_held", sample_ready, 0);
        capture(32, 0, 0);
        chk("nobyp_data", cap_bits, 32'h0000C35A);
        chk("nobyp_lr", cap_lr, 32'h01FE01FE);
        chk("nobyp_fs2", cap_fs, 1);
        chk("nobyp_ur2", cap_ur, 0);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);

        // enable dropped at bit 5, held pair survives
        offer(8'h04, 8'h00);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        offer(8'h96, 8'h69);
        repeat (20) @(negedge clk);
        chk("bit5_bclk", bclk, 1);
        chk("bit5_sdata", sdata, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_lines", {bclk, lrclk, sdata, frame_start, underrun}, 0);
        chk("dis_hold_kept", sample_ready, 0);
        repeat (3) @(negedge clk);
        enable = 1'b1;
        capture(16, 1, 0);
        chk("reen_data", cap_bits[15:0], 16'h9669);
        chk("reen_lr", cap_lr[15:0], 16'h01FE);
        chk("reen_fs", cap_fs, 1);
        chk("reen_ur", cap_ur, 0);
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);

        // async reset mid-frame with a pair held
        offer(8'hFF, 8'hFF);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        offer(8'hAA, 8'h55);
        begin
            int k = 0;
            while (!(bclk && sdata && lrclk) && k < 300) begin
                @(negedge clk);
                k++;
            end
            chk("rst_wait", k < 300, 1);
        end
        #2 rst = 1'b1;
        #1;
        chk("async_rst_lines", {bclk, lrclk, sdata, frame_start, underrun}, 0);
        chk("async_rst_ready", sample_ready, 1);
        @(negedge clk);
        enable = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        chk("rel_rst_ready", sample_ready, 1);
        chk("rel_rst_lines", {bclk, lrclk, sdata}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
